// File: rtl/btb_pkg.sv
// btb_pkg: shared types, counter constants and default field widths for the 2-way BTB.
package btb_pkg;
  typedef enum logic {SWEEP, RUN} state_t;
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_MAX = 2'b11;
  localparam int PC_W_D = 13;
  localparam int IDX_W_D = 9;
  localparam int TAG_W_D = PC_W_D - IDX_W_D;
  localparam int CTR_W = 2;
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic tk);
    return tk ? (c == CTR_MAX ? c : c + 2'd1) : (c == 2'd0 ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/btb_2way_if.sv
// btb_2way_if: fetch lookup, branch update and flush signals of the BTB.
interface btb_2way_if #(parameter int PC_W = 13);
  logic            flush;
  logic [PC_W-1:0] pcF;
  logic [PC_W-1:0] prepc;
  logic            hit_predict;
  logic            ready;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  modport master(output flush, pcF, upd_valid, upd_pc, upd_taken, upd_target,
                 input prepc, hit_predict, ready);
  modport slave(input flush, pcF, upd_valid, upd_pc, upd_taken, upd_target,
                output prepc, hit_predict, ready);
endinterface

// File: rtl/btb_way.sv
// btb_way: one BTB way; two async read ports (lookup, update) and one sync write port.
module btb_way import btb_pkg::*; #(
  parameter int PC_W = PC_W_D,
  parameter int IDX_W = IDX_W_D,
  localparam int TAG_W = PC_W - IDX_W,
  localparam int SETS = 2 ** IDX_W
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] i_ra,
  input  logic [IDX_W-1:0] i_rb,
  output logic             o_va,
  output logic             o_vb,
  output logic [TAG_W-1:0] o_ta,
  output logic [TAG_W-1:0] o_tb,
  output logic [PC_W-1:0]  o_ga,
  output logic [PC_W-1:0]  o_gb,
  output logic [1:0]       o_ca,
  output logic [1:0]       o_cb,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wa,
  input  logic             i_wv,
  input  logic [TAG_W-1:0] i_wt,
  input  logic [PC_W-1:0]  i_wg,
  input  logic [1:0]       i_wc
);
  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag [SETS];
  logic [PC_W-1:0]  r_tgt [SETS];
  logic [1:0]       r_ctr [SETS];
  always_ff @(posedge clk)
    if (i_we) begin
      r_valid[i_wa] <= i_wv;
      r_tag[i_wa]   <= i_wt;
      r_tgt[i_wa]   <= i_wg;
      r_ctr[i_wa]   <= i_wc;
    end
  assign o_va = r_valid[i_ra];
  assign o_vb = r_valid[i_rb];
  assign o_ta = r_tag[i_ra];
  assign o_tb = r_tag[i_rb];
  assign o_ga = r_tgt[i_ra];
  assign o_gb = r_tgt[i_rb];
  assign o_ca = r_ctr[i_ra];
  assign o_cb = r_ctr[i_rb];
endmodule

// File: rtl/btb_2way.sv
// btb_2way: 2-way set-associative BTB with 2-bit counters, per-set LRU and an
// invalidate-all sweep that runs after reset and on flush.
module btb_2way import btb_pkg::*; #(
  parameter int PC_W = PC_W_D,
  parameter int IDX_W = IDX_W_D
) (
  input logic        CLK,
  input logic        RST,
  btb_2way_if.slave  bus
);
  localparam int TAG_W = PC_W - IDX_W;
  localparam int SETS = 2 ** IDX_W;
  state_t           r_state;
  logic [IDX_W-1:0] r_cnt;
  logic [SETS-1:0]  r_lru;
  logic             w_ready, w_sweep, w_upd, w_wr, w_uway;
  logic [IDX_W-1:0] w_lidx, w_uidx, w_wa;
  logic [TAG_W-1:0] w_ltag, w_utag;
  logic             w_lv [2];
  logic             w_uv [2];
  logic [TAG_W-1:0] w_lt [2];
  logic [TAG_W-1:0] w_ut [2];
  logic [PC_W-1:0]  w_lg [2];
  logic [PC_W-1:0]  w_ug [2];
  logic [1:0]       w_lc [2];
  logic [1:0]       w_uc [2];
  logic [1:0]       w_we, w_lhit, w_uhit;
  logic [PC_W-1:0]  w_wg;
  logic [1:0]       w_wc;
  assign w_ready = r_state == RUN;
  assign w_sweep = r_state == SWEEP;
  assign {w_ltag, w_lidx} = bus.pcF;
  assign {w_utag, w_uidx} = bus.upd_pc;
  assign w_upd = bus.upd_valid & w_ready & ~bus.flush;
  // Hit updates the matching way (way 0 first); a taken miss allocates the LRU victim.
  assign w_uway = w_uhit[0] ? 1'b0 : w_uhit[1] ? 1'b1 : r_lru[w_uidx];
  assign w_wr = w_upd & (|w_uhit | bus.upd_taken);
  assign w_wa = w_sweep ? r_cnt : w_uidx;
  assign w_wg = bus.upd_taken ? bus.upd_target : w_ug[w_uway];
  assign w_wc = |w_uhit ? ctr_next(w_uc[w_uway], bus.upd_taken) : CTR_WT;
  for (genvar w = 0; w < 2; w++) begin : g_way
    btb_way #(.PC_W(PC_W), .IDX_W(IDX_W)) u_way (
      .clk(CLK), .i_ra(w_lidx), .i_rb(w_uidx),
      .o_va(w_lv[w]), .o_vb(w_uv[w]), .o_ta(w_lt[w]), .o_tb(w_ut[w]),
      .o_ga(w_lg[w]), .o_gb(w_ug[w]), .o_ca(w_lc[w]), .o_cb(w_uc[w]),
      .i_we(w_we[w]), .i_wa(w_wa), .i_wv(~w_sweep), .i_wt(w_utag),
      .i_wg(w_wg), .i_wc(w_wc)
    );
    assign w_lhit[w] = w_ready & w_lv[w] & (w_lt[w] == w_ltag);
    assign w_uhit[w] = w_uv[w] & (w_ut[w] == w_utag);
    assign w_we[w] = w_sweep | (w_wr & (w_uway == 1'(w)));
  end
  assign bus.ready = w_ready;
  assign bus.hit_predict = w_lhit[0] ? w_lc[0][1] : w_lhit[1] & w_lc[1][1];
  assign bus.prepc = w_lhit[0] ? w_lg[0] : w_lhit[1] ? w_lg[1] : '0;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_state <= SWEEP;
      r_cnt   <= '0;
    end else if (bus.flush) begin
      r_state <= SWEEP;
      r_cnt   <= '0;
    end else if (w_sweep) begin
      r_cnt   <= r_cnt + 1'b1;
      r_state <= r_cnt == IDX_W'(SETS - 1) ? RUN : SWEEP;
    end
  always_ff @(posedge CLK)
    if (w_sweep) r_lru[r_cnt] <= 1'b0;
    else if (w_wr) r_lru[w_uidx] <= ~w_uway;
endmodule

// File: tb/tb_btb_2way.sv
// tb_btb_2way: directed scoreboard bench; stimulus queues expected {ready,hit,prepc},
// a negedge monitor pops and compares whenever a lookup is presented.
module tb_btb_2way;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  btb_2way_if #(.PC_W(13)) bif();
  btb_2way #(.PC_W(13), .IDX_W(9)) dut(.CLK(clk), .RST(rst), .bus(bif.slave));
  logic [14:0] q_exp[$];
  string       q_nm[$];
  logic        chk = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [14:0] m_act, m_exp;
  string       m_nm;
  always @(negedge clk)
    if (chk) begin
      m_act = {bif.ready, bif.hit_predict, bif.prepc};
      n_chk++;
      if (q_exp.size() == 0) $display("FAIL no_expect: got %b/%b/%h with nothing queued", m_act[14], m_act[13], m_act[12:0]);
      else begin
        m_exp = q_exp.pop_front();
        m_nm = q_nm.pop_front();
        if (m_act === m_exp) n_pass++;
        else $display("FAIL %s: ready/hit/prepc got %b/%b/%h want %b/%b/%h", m_nm,
                      m_act[14], m_act[13], m_act[12:0], m_exp[14], m_exp[13], m_exp[12:0]);
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
    chk = 0;
    bif.upd_valid = 0;
    bif.flush = 0;
  endtask
  task automatic look(input logic [12:0] pc, input logic r, input logic h, input logic [12:0] t, input string nm);
    bif.pcF = pc;
    q_exp.push_back({r, h, t});
    q_nm.push_back(nm);
    chk = 1;
    step();
  endtask
  task automatic upd(input logic [12:0] pc, input logic tk, input logic [12:0] t);
    bif.upd_valid = 1;
    bif.upd_pc = pc;
    bif.upd_taken = tk;
    bif.upd_target = t;
  endtask
  initial begin
    bif.flush = 0; bif.pcF = 0; bif.upd_valid = 0; bif.upd_pc = 0; bif.upd_taken = 0; bif.upd_target = 0;
    repeat (2) @(posedge clk);
    #1;
    look(13'h0123, 0, 0, 13'h0, "reset_state");
    rst = 0;
    for (int i = 0; i < 512; i++) look(13'(i * 7), 0, 0, 13'h0, "reset_sweep");
    look(13'h0123, 1, 0, 13'h0, "ready_after_sweep");
    upd(13'h0123, 1, 13'h0400); step();
    look(13'h0123, 1, 1, 13'h0400, "alloc_hit");
    look(13'h0323, 1, 0, 13'h0, "alloc_other_tag");
    upd(13'h0123, 0, 13'h1fff); step();
    look(13'h0123, 1, 0, 13'h0400, "ctr_01");
    upd(13'h0123, 1, 13'h0400); step();
    upd(13'h0123, 1, 13'h0400); step();
    look(13'h0123, 1, 1, 13'h0400, "ctr_11");
    upd(13'h0123, 0, 13'h1fff); step();
    look(13'h0123, 1, 1, 13'h0400, "ctr_10_hyst");
    upd(13'h0123, 1, 13'h0500); step();
    look(13'h0123, 1, 1, 13'h0500, "target_update");
    upd(13'h0323, 0, 13'h0999); step();
    look(13'h0323, 1, 0, 13'h0, "nt_miss_noalloc");
    upd(13'h0010, 1, 13'h0a00); step();
    upd(13'h0210, 1, 13'h0b00); step();
    upd(13'h0410, 1, 13'h0c00); step();
    look(13'h0010, 1, 0, 13'h0, "lru_evicted");
    look(13'h0210, 1, 1, 13'h0b00, "lru_keep_0210");
    look(13'h0410, 1, 1, 13'h0c00, "lru_keep_0410");
    upd(13'h0077, 1, 13'h0777);
    look(13'h0077, 1, 0, 13'h0, "rw_same_cycle");
    look(13'h0077, 1, 1, 13'h0777, "rw_next_cycle");
    bif.flush = 1;
    upd(13'h0055, 1, 13'h0555);
    look(13'h0055, 1, 0, 13'h0, "flush_cycle");
    for (int i = 0; i < 512; i++) begin
      if (i == 10) upd(13'h0066, 1, 13'h0666);
      look(13'h0066, 0, 0, 13'h0, "flush_sweep");
    end
    look(13'h0055, 1, 0, 13'h0, "flush_upd_dropped");
    look(13'h0066, 1, 0, 13'h0, "sweep_upd_dropped");
    look(13'h0123, 1, 0, 13'h0, "flushed_0123");
    look(13'h0210, 1, 0, 13'h0, "flushed_0210");
    bif.flush = 1;
    look(13'h0, 1, 0, 13'h0, "flush2_cycle");
    for (int i = 0; i < 100; i++) look(13'h0, 0, 0, 13'h0, "flush2_sweep");
    bif.flush = 1;
    look(13'h0, 0, 0, 13'h0, "reflush_cycle");
    for (int i = 0; i < 512; i++) look(13'h0, 0, 0, 13'h0, "restart_sweep");
    look(13'h0, 1, 0, 13'h0, "restart_done");
    step();
    step();
    if (q_exp.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expected entries left, want 0", q_exp.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
